// File: rtl/sev_seg_mux_controller_if.sv
// sev_seg_mux_controller_if: request side of the rd/wr/data_mask system bus.
interface sev_seg_mux_controller_if;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  data_mask;
    modport master (output addr, rd, wr, data_mask);
    modport slave  (input addr, rd, wr, data_mask);
endinterface

// File: rtl/sev_seg_mux_controller.sv
// sev_seg_mux_controller: bus-mapped multi-digit seven-segment scanner with PWM, blink and hex decode.
module sev_seg_mux_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DIGITS    = 4,
    parameter int          CLK_DIV   = 1000,
    parameter int          BLINK_DIV = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    sev_seg_mux_controller_if.slave bus,
    inout  wire  [31:0]            data_bus,
    output wire                    fc_bus,
    output logic [6:0]             seg_n,
    output logic                   dp_n,
    output logic [DIGITS-1:0]      an_n
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);
    localparam logic [7:0] DOT_MASK = 8'((9'd1 << DIGITS) - 9'd1);
    localparam logic [15:0][6:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic            en, hex_mode, blink_en, blink_phase, data_written;
    logic [3:0]      bright, pwm_cnt;
    logic [7:0][6:0] dig;
    logic [7:0]      dots;
    logic [PW-1:0]   presc;
    logic [2:0]      slot, off;
    logic [FW-1:0]   frame;
    logic [31:0]     rdata;
    logic [6:0]      pattern;
    logic [7:0]      an_sel;
    logic            hit, read_req, write_req, lit, unused_bits;

    assign off       = bus.addr[4:2];
    assign hit       = bus.addr[31:5] == BASE_ADDR[31:5] && bus.addr[1:0] == 2'b00 && off <= 3'd4;
    assign read_req  = hit && bus.rd && !bus.wr;
    assign write_req = hit && bus.wr && !bus.rd;
    assign data_bus  = read_req ? rdata : 'z;
    assign fc_bus    = read_req ? 1'b1 : write_req ? data_written : 1'bz;
    assign unused_bits = ^{data_bus[31], data_bus[23], data_bus[15]};

    always_comb begin
        rdata = '0;
        case (off)
            3'd0: rdata = {20'd0, bright, 5'd0, blink_en, hex_mode, en};
            3'd1: rdata = {21'd0, slot, 7'd0, 1'b1};
            3'd2: rdata = {1'b0, dig[3], 1'b0, dig[2], 1'b0, dig[1], 1'b0, dig[0]};
            3'd3: rdata = {1'b0, dig[7], 1'b0, dig[6], 1'b0, dig[5], 1'b0, dig[4]};
            3'd4: rdata = {24'd0, dots};
            default: rdata = '0;
        endcase
    end

    // Digits beyond DIGITS are never written, so they stay 0 and read back as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {blink_en, hex_mode, en} <= '0;
            bright       <= '0;
            dots         <= '0;
            dig          <= '0;
            data_written <= 1'b0;
        end else begin
            data_written <= write_req;
            if (write_req && !data_written) begin
                if (off == 3'd0 && bus.data_mask[0]) {blink_en, hex_mode, en} <= data_bus[2:0];
                if (off == 3'd0 && bus.data_mask[1]) bright <= data_bus[11:8];
                if (off == 3'd4 && bus.data_mask[0]) dots <= data_bus[7:0] & DOT_MASK;
                for (int k = 0; k < DIGITS; k++)
                    if (off == 3'(2 + k / 4) && bus.data_mask[k % 4]) dig[k] <= data_bus[(k % 4) * 8 +: 7];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            presc       <= '0;
            slot        <= '0;
            frame       <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            presc   <= presc == PW'(CLK_DIV - 1) ? '0 : presc + PW'(1);
            if (presc == PW'(CLK_DIV - 1)) begin
                slot <= slot == 3'(DIGITS - 1) ? 3'd0 : slot + 3'd1;
                if (slot == 3'(DIGITS - 1)) begin
                    frame <= frame == FW'(BLINK_DIV - 1) ? '0 : frame + FW'(1);
                    if (frame == FW'(BLINK_DIV - 1)) blink_phase <= !blink_phase;
                end
            end
        end
    end

    assign pattern = hex_mode ? HEX[dig[slot][3:0]] : dig[slot];
    assign lit     = en && pwm_cnt <= bright && !(blink_en && blink_phase);
    assign an_sel  = 8'd1 << slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= lit ? ~an_sel[DIGITS-1:0] : '1;
            seg_n <= lit ? ~pattern : 7'h7F;
            dp_n  <= lit ? ~dots[slot] : 1'b1;
        end
    end
endmodule

// File: tb/tb_sev_seg_mux_controller.sv
// tb_sev_seg_mux_controller: directed checks of bus access, scan, PWM, blink and invalid requests.
// Floating bus lines are pulled (data up, fc down) so high-Z is observable as a fixed value.
module tb_sev_seg_mux_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sev_seg_mux_controller_if bus();
    wire  [31:0] data_bus;
    wire         fc_bus;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        drv = 1'b0;
    logic [31:0] wdata = '0;

    assign data_bus = drv ? wdata : 'z;
    pullup (data_bus);
    pulldown (fc_bus);

    sev_seg_mux_controller #(.BASE_ADDR(32'h0), .DIGITS(4), .CLK_DIV(16), .BLINK_DIV(1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .data_bus(data_bus), .fc_bus(fc_bus),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic f);
        @(negedge clk);
        bus.addr = a;
        bus.rd = 1'b1;
        #1;
        d = data_bus;
        f = fc_bus;
        bus.rd = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic f;
        bus_read(a, d, f);
        check(tag, d, exp);
        check({tag, "_fc"}, 32'(f), 32'd1);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.addr = a;
        bus.data_mask = m;
        wdata = d;
        drv = 1'b1;
        bus.wr = 1'b1;
        #1;
        check("wr_fc_pending", 32'(fc_bus), 32'd0);
        @(negedge clk);
        check("wr_fc_done", 32'(fc_bus), 32'd1);
        bus.wr = 1'b0;
        drv = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] v, input string tag);
        int n = 0;
        while (an_n != v && n < 300) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(an_n), 32'(v));
    endtask

    task automatic run_len(input logic [3:0] v, output int n);
        n = 0;
        while (an_n == v && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_lit(output int n);
        n = 0;
        while (an_n != 4'hF && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [3:0]  scan_an  [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0]  scan_seg [4] = '{7'h7F, 7'h24, 7'h7F, 7'h40};
    logic        scan_dp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int n, e_cnt, rises, multi;
        logic [3:0] prev;
        bit seg_seen;
        logic [31:0] d;
        logic f;
        bus.addr = '0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.data_mask = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_an", 32'(an_n), 32'hF);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_dp", 32'(dp_n), 32'h1);
        read_check("rst_ctrl", 32'h00, 32'h0);
        read_check("rst_diglo", 32'h08, 32'h0);
        read_check("rst_dots", 32'h10, 32'h0);
        @(negedge clk) rst = 1'b0;

        bus_write(32'h08, 32'h4F5B063F, 4'b0101);
        read_check("diglo_mask", 32'h08, 32'h005B003F);
        bus_write(32'h0C, 32'hFFFFFFFF, 4'hF);
        read_check("dighi_absent", 32'h0C, 32'h0);
        bus_write(32'h00, 32'hFFFFFFFF, 4'hF);
        read_check("ctrl_bits", 32'h00, 32'h00000F07);
        bus_write(32'h00, 32'h0, 4'hF);
        bus_write(32'h04, 32'hFFFFFFFF, 4'hF);
        read_check("status_ro", 32'h04, 32'h1);
        bus_write(32'h10, 32'hFF, 4'h1);
        read_check("dots_width", 32'h10, 32'hF);
        bus_write(32'h10, 32'h2, 4'h1);

        bus_write(32'h00, 32'h0F01, 4'b0011);
        wait_an(4'hD, "scan_sync");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("scan_an%0d", i), 32'(an_n), 32'(scan_an[i]));
            check($sformatf("scan_seg%0d", i), 32'(seg_n), 32'(scan_seg[i]));
            check($sformatf("scan_dp%0d", i), 32'(dp_n), 32'(scan_dp[i]));
            run_len(scan_an[i], n);
            check($sformatf("scan_len%0d", i), n, 32'd16);
        end

        bus_write(32'h08, 32'h0000000A, 4'b0001);
        bus_write(32'h00, 32'h0303, 4'b0011);
        wait_an(4'hD, "pwm_sync");
        e_cnt = 0;
        rises = 0;
        multi = 0;
        prev = 4'hF;
        seg_seen = 1'b0;
        repeat (64) begin
            if (an_n == 4'hE) begin
                e_cnt++;
                if (prev != 4'hE) rises++;
                if (!seg_seen) begin
                    check("pwm_seg", 32'(seg_n), 32'h08);
                    seg_seen = 1'b1;
                end
            end
            if ($countones(~an_n) > 1) multi++;
            prev = an_n;
            @(negedge clk);
        end
        check("pwm_on_cycles", e_cnt, 32'd4);
        check("pwm_one_burst", rises, 32'd1);
        check("an_onehot", multi, 32'd0);

        bus_write(32'h00, 32'h0F05, 4'b0011);
        wait_an(4'hF, "blink_dark_seen");
        run_len(4'hF, n);
        run_lit(n);
        check("blink_lit_len", n, 32'd64);
        run_len(4'hF, n);
        check("blink_dark_len", n, 32'd64);
        run_lit(n);
        check("blink_lit_len2", n, 32'd64);
        run_len(4'hF, n);
        check("lit_before_clear", 32'(an_n != 4'hF), 32'd1);
        bus_write(32'h00, 32'h0, 4'b0011);
        check("clear_an", 32'(an_n), 32'hF);
        check("clear_seg", 32'(seg_n), 32'h7F);
        check("clear_dp", 32'(dp_n), 32'h1);
        read_check("clear_status", 32'h04, 32'h1);

        @(negedge clk);
        bus.addr = 32'h08;
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        #1;
        check("rdwr_data_z", data_bus, 32'hFFFFFFFF);
        check("rdwr_fc_z", 32'(fc_bus), 32'd0);
        drv = 1'b1;
        wdata = 32'h11223344;
        bus.data_mask = 4'hF;
        repeat (2) @(negedge clk);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        drv = 1'b0;
        read_check("rdwr_kept", 32'h08, 32'h005B000A);

        bus_read(32'h14, d, f);
        check("miss14_data_z", d, 32'hFFFFFFFF);
        check("miss14_fc_z", 32'(f), 32'd0);
        bus_read(32'h09, d, f);
        check("unaligned_data_z", d, 32'hFFFFFFFF);
        @(negedge clk);
        bus.addr = 32'h14;
        bus.wr = 1'b1;
        drv = 1'b1;
        wdata = 32'hFFFFFFFF;
        #1;
        check("miss14_wr_fc_z", 32'(fc_bus), 32'd0);
        repeat (2) @(negedge clk);
        bus.wr = 1'b0;
        drv = 1'b0;
        read_check("miss_ctrl_kept", 32'h00, 32'h0);
        read_check("miss_diglo_kept", 32'h08, 32'h005B000A);
        read_check("miss_dots_kept", 32'h10, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
